// File: rtl/clk_gate_ctrl.sv
// ----------------------------------------------------------------------------
// clk_gate_ctrl
//
// Multi-channel clock-gate controller with per-channel gated data capture.
// Each channel registers its enable request, then runs a CLOSED/OPEN/DRAIN
// FSM. The DRAIN state keeps a gate open for IDLE_CYCLES cycles after the
// request drops. Gate enables are decoded straight from state flops, so the
// downstream ICG cells always see a glitch-free, flop-sourced enable.
// The per-channel capture register behaves like a flop on the gated clock.
// It loads the pre-edge data only when the gate was open in the cycle that
// is ending.
//
// Handshake / timing contract: there is no valid/ready handshake. en_req is
// a level request. gate_en follows it two edges later: one edge for en_q and
// one for the FSM. force_off overrides force_on, and force_on overrides
// en_req.
//
// Ports:
//   clk        in   1          clock, all state on posedge
//   rst_n      in   1          synchronous active-low reset
//   en_req     in   NCH        per-channel gate request
//   force_on   in   1          open every gate and hold it open
//   force_off  in   1          close every gate (highest priority)
//   d          in   NCH*WIDTH  channel data, channel i = d[i*WIDTH +: WIDTH]
//   gate_en    out  NCH        per-channel gate enable (state decode)
//   q          out  NCH*WIDTH  per-channel captured data
//   wake       out  NCH        pulse in the first open cycle after closed
//   open_cnt   out  CNT_W      number of open gates
//   state_dbg  out  2*NCH      FSM state per channel, channel i = [2*i +: 2]
// ----------------------------------------------------------------------------
module clk_gate_ctrl #(
   parameter int NCH         = 8,
   parameter int WIDTH       = 1,
   parameter int IDLE_CYCLES = 4,
   parameter int IDLE_W      = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1,
   parameter int CNT_W       = $clog2(NCH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH-1:0]         en_req,
   input  logic                   force_on,
   input  logic                   force_off,
   input  logic [NCH*WIDTH-1:0]   d,
   output logic [NCH-1:0]         gate_en,
   output logic [NCH*WIDTH-1:0]   q,
   output logic [NCH-1:0]         wake,
   output logic [CNT_W-1:0]       open_cnt,
   output logic [2*NCH-1:0]       state_dbg
);

   typedef enum logic [1:0] {
      ST_CLOSED = 2'd0,
      ST_OPEN   = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   // The counter counts down to zero while in DRAIN. Loading IDLE_CYCLES-1
   // gives exactly IDLE_CYCLES open cycles after en_q drops.
   localparam logic [IDLE_W-1:0] DRAIN_LOAD =
      (IDLE_CYCLES > 0) ? IDLE_W'(IDLE_CYCLES - 1) : '0;

   state_e                 state_q [NCH];
   state_e                 state_d [NCH];
   logic [IDLE_W-1:0]      cnt_q   [NCH];
   logic [IDLE_W-1:0]      cnt_d   [NCH];
   logic [NCH-1:0]         en_q;
   logic [NCH-1:0]         wake_q;
   logic [NCH-1:0]         wake_d;
   logic [NCH*WIDTH-1:0]   q_q;
   logic [NCH*WIDTH-1:0]   q_d;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en_q   <= '0;
         wake_q <= '0;
         q_q    <= '0;
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= ST_CLOSED;
            cnt_q[i]   <= '0;
         end
      end else begin
         en_q   <= en_req;
         wake_q <= wake_d;
         q_q    <= q_d;
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         if (force_off) begin
            state_d[i] = ST_CLOSED;
            cnt_d[i]   = '0;
         end else if (force_on) begin
            state_d[i] = ST_OPEN;
         end else begin
            case (state_q[i])
               ST_CLOSED: begin
                  if (en_q[i]) state_d[i] = ST_OPEN;
               end
               ST_OPEN: begin
                  if (!en_q[i]) begin
                     if (IDLE_CYCLES == 0) begin
                        state_d[i] = ST_CLOSED;
                     end else begin
                        state_d[i] = ST_DRAIN;
                        cnt_d[i]   = DRAIN_LOAD;
                     end
                  end
               end
               ST_DRAIN: begin
                  if (en_q[i]) begin
                     state_d[i] = ST_OPEN;
                  end else if (cnt_q[i] == '0) begin
                     state_d[i] = ST_CLOSED;
                  end else begin
                     cnt_d[i] = cnt_q[i] - 1'b1;
                  end
               end
               default: begin
                  state_d[i] = ST_CLOSED;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   // -------------------------------------------------------------------------
   // Output logic
   // -------------------------------------------------------------------------
   always_comb begin
      gate_en   = '0;
      wake_d    = '0;
      q_d       = q_q;
      state_dbg = '0;
      for (int i = 0; i < NCH; i++) begin
         gate_en[i]          = (state_q[i] != ST_CLOSED);
         wake_d[i]           = (state_d[i] != ST_CLOSED) && (state_q[i] == ST_CLOSED);
         state_dbg[2*i +: 2] = state_q[i];
         // Capture only if this cycle had the gate open. This uses the
         // pre-edge d, like a flop on the gated clock.
         if (state_q[i] != ST_CLOSED) q_d[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
      end
   end

   // Population count of the open gates.
   always_comb begin
      open_cnt = '0;
      for (int i = 0; i < NCH; i++) begin
         open_cnt = open_cnt + CNT_W'(gate_en[i]);
      end
   end

   assign q    = q_q;
   assign wake = wake_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clk_gate_ctrl
//
// Directed bench for clk_gate_ctrl with the default parameters:
// NCH=8, WIDTH=1, IDLE_CYCLES=4. Inputs are driven 1 time unit after each
// posedge. Outputs are sampled at the same point, so every sample reflects
// the state left by the edge just taken.
// ----------------------------------------------------------------------------
module tb_clk_gate_ctrl;

   localparam int NCH   = 8;
   localparam int WIDTH = 1;
   localparam int IDLE  = 4;
   localparam int CNT_W = $clog2(NCH + 1);

   logic                 clk;
   logic                 rst_n;
   logic [NCH-1:0]       en_req;
   logic                 force_on;
   logic                 force_off;
   logic [NCH*WIDTH-1:0] d;
   logic [NCH-1:0]       gate_en;
   logic [NCH*WIDTH-1:0] q;
   logic [NCH-1:0]       wake;
   logic [CNT_W-1:0]     open_cnt;
   logic [2*NCH-1:0]     state_dbg;

   int checks;
   int errors;

   clk_gate_ctrl #(
      .NCH         (NCH),
      .WIDTH       (WIDTH),
      .IDLE_CYCLES (IDLE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_req    (en_req),
      .force_on  (force_on),
      .force_off (force_off),
      .d         (d),
      .gate_en   (gate_en),
      .q         (q),
      .wake      (wake),
      .open_cnt  (open_cnt),
      .state_dbg (state_dbg)
   );

   // -------------------------------------------------------------------------
   // Clock and reset
   // -------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // -------------------------------------------------------------------------
   // Test 1: reset holds everything low even with requests and force_on
   // -------------------------------------------------------------------------
   task automatic test_reset();
      rst_n     = 1'b0;
      en_req    = 8'hFF;
      force_on  = 1'b1;
      force_off = 1'b0;
      d         = 8'hC3;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (gate_en !== 8'h00) begin errors++; $display("FAIL reset_gate_en c%0d got %h exp 00", c, gate_en); end
         checks++;
         if (q !== 8'h00) begin errors++; $display("FAIL reset_q c%0d got %h exp 00", c, q); end
         checks++;
         if (wake !== 8'h00) begin errors++; $display("FAIL reset_wake c%0d got %h exp 00", c, wake); end
         checks++;
         if (open_cnt !== 4'd0) begin errors++; $display("FAIL reset_open_cnt c%0d got %0d exp 0", c, open_cnt); end
      end
      rst_n    = 1'b1;
      en_req   = 8'h00;
      force_on = 1'b0;
      d        = 8'h00;
      tick();
      tick();
      checks++;
      if (gate_en !== 8'h00) begin errors++; $display("FAIL post_reset_idle got %h exp 00", gate_en); end
   endtask

   // -------------------------------------------------------------------------
   // Test 2: two-edge open latency with a single wake pulse
   // -------------------------------------------------------------------------
   task automatic test_open_latency();
      en_req = 8'h01;
      tick();
      checks++;
      if (gate_en !== 8'h00) begin errors++; $display("FAIL lat_edge1_gate got %h exp 00", gate_en); end
      tick();
      checks++;
      if (gate_en !== 8'h01) begin errors++; $display("FAIL lat_edge2_gate got %h exp 01", gate_en); end
      checks++;
      if (wake !== 8'h01) begin errors++; $display("FAIL lat_edge2_wake got %h exp 01", wake); end
      checks++;
      if (open_cnt !== 4'd1) begin errors++; $display("FAIL lat_open_cnt got %0d exp 1", open_cnt); end
      tick();
      checks++;
      if (wake !== 8'h00) begin errors++; $display("FAIL lat_edge3_wake got %h exp 00", wake); end
      checks++;
      if (gate_en !== 8'h01) begin errors++; $display("FAIL lat_edge3_gate got %h exp 01", gate_en); end
   endtask

   // -------------------------------------------------------------------------
   // Test 3: idle hysteresis and re-request during drain
   // -------------------------------------------------------------------------
   task automatic test_hysteresis();
      // The gate is open here. Drop the request.
      en_req = 8'h00;
      tick();   // en_q drops; the state is still OPEN
      checks++;
      if (gate_en[0] !== 1'b1) begin errors++; $display("FAIL hyst_k got %b exp 1", gate_en[0]); end
      for (int c = 1; c <= IDLE; c++) begin
         tick();
         checks++;
         if (gate_en[0] !== 1'b1) begin errors++; $display("FAIL hyst_drain%0d got %b exp 1", c, gate_en[0]); end
      end
      tick();
      checks++;
      if (gate_en[0] !== 1'b0) begin errors++; $display("FAIL hyst_closed got %b exp 0", gate_en[0]); end

      // Reopen the gate.
      en_req = 8'h01;
      tick();
      tick();
      checks++;
      if (wake[0] !== 1'b1) begin errors++; $display("FAIL rereq_open_wake got %b exp 1", wake[0]); end
      tick();
      // Drop the request, then raise it again so that en_q is high during
      // the second drain cycle.
      en_req = 8'h00;
      tick();   // OPEN with en_q=0
      tick();   // first drain cycle
      en_req = 8'h01;
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++;
         if (gate_en[0] !== 1'b1) begin errors++; $display("FAIL rereq_gate c%0d got %b exp 1", c, gate_en[0]); end
         checks++;
         if (wake[0] !== 1'b0) begin errors++; $display("FAIL rereq_wake c%0d got %b exp 0", c, wake[0]); end
      end
      en_req = 8'h00;
      for (int c = 0; c < IDLE + 2; c++) tick();
      checks++;
      if (gate_en !== 8'h00) begin errors++; $display("FAIL rereq_final_close got %h exp 00", gate_en); end
   endtask

   // -------------------------------------------------------------------------
   // Test 4: capture against a reference model of channel 0
   // -------------------------------------------------------------------------
   task automatic test_capture();
      logic [7:0] crc;
      logic       cur_en;
      logic       m_en_q;
      logic       m_q;
      logic       m_wake;
      int         m_st;    // 0 closed, 1 open, 2 drain
      int         m_prev;
      int         m_cnt;
      crc    = 8'h5A;
      m_en_q = 1'b0;
      m_q    = 1'b0;
      m_st   = 0;
      m_cnt  = 0;
      for (int c = 0; c < 100; c++) begin
         cur_en = 1'($urandom_range(0, 1));
         en_req = {7'b0, cur_en};
         d      = crc;
         tick();
         // Model the edge using the pre-edge values.
         m_prev = m_st;
         if (m_st != 0) m_q = crc[0];
         case (m_st)
            0: if (m_en_q) m_st = 1;
            1: if (!m_en_q) begin m_st = 2; m_cnt = IDLE - 1; end
            default: begin
               if (m_en_q) m_st = 1;
               else if (m_cnt == 0) m_st = 0;
               else m_cnt = m_cnt - 1;
            end
         endcase
         m_wake = (m_st != 0) && (m_prev == 0);
         m_en_q = cur_en;
         checks++;
         if (gate_en[0] !== (m_st != 0)) begin errors++; $display("FAIL cap_gate c%0d got %b exp %b", c, gate_en[0], (m_st != 0)); end
         checks++;
         if (q[0] !== m_q) begin errors++; $display("FAIL cap_q c%0d got %b exp %b", c, q[0], m_q); end
         checks++;
         if (wake[0] !== m_wake) begin errors++; $display("FAIL cap_wake c%0d got %b exp %b", c, wake[0], m_wake); end
         crc = {crc[6:0], crc[7] ^ crc[5] ^ crc[4] ^ crc[3]};
      end
      en_req = 8'h00;
      d      = 8'h00;
      for (int c = 0; c < IDLE + 3; c++) tick();
      checks++;
      if (gate_en !== 8'h00) begin errors++; $display("FAIL cap_final_close got %h exp 00", gate_en); end
   endtask

   // -------------------------------------------------------------------------
   // Test 5: force_on / force_off overrides
   // -------------------------------------------------------------------------
   task automatic test_overrides();
      force_on = 1'b1;
      en_req   = 8'h00;
      d        = 8'hA5;
      tick();
      checks++;
      if (gate_en !== 8'hFF) begin errors++; $display("FAIL fon_gate got %h exp ff", gate_en); end
      checks++;
      if (open_cnt !== 4'd8) begin errors++; $display("FAIL fon_open_cnt got %0d exp 8", open_cnt); end
      checks++;
      if (wake !== 8'hFF) begin errors++; $display("FAIL fon_wake got %h exp ff", wake); end
      tick();
      checks++;
      if (q !== 8'hA5) begin errors++; $display("FAIL fon_capture got %h exp a5", q); end

      // Both forces high: force_off wins. The closing edge still captures
      // 3C because the gate was open in the cycle before it.
      d         = 8'h3C;
      force_off = 1'b1;
      tick();
      checks++;
      if (gate_en !== 8'h00) begin errors++; $display("FAIL foff_gate got %h exp 00", gate_en); end
      checks++;
      if (open_cnt !== 4'd0) begin errors++; $display("FAIL foff_open_cnt got %0d exp 0", open_cnt); end
      checks++;
      if (q !== 8'h3C) begin errors++; $display("FAIL foff_last_capture got %h exp 3c", q); end
      d = 8'hFF;
      tick();
      checks++;
      if (q !== 8'h3C) begin errors++; $display("FAIL foff_q_hold got %h exp 3c", q); end

      // force_off also beats en_req.
      force_on = 1'b0;
      en_req   = 8'hFF;
      tick();
      tick();
      checks++;
      if (gate_en !== 8'h00) begin errors++; $display("FAIL foff_over_req got %h exp 00", gate_en); end
      force_off = 1'b0;
      tick();   // en_q is already high, so the gates open on this edge
      checks++;
      if (gate_en !== 8'hFF) begin errors++; $display("FAIL foff_release got %h exp ff", gate_en); end

      // Releasing force_on with en_q=0 starts the normal drain.
      d        = 8'h00;
      force_on = 1'b1;
      en_req   = 8'h00;
      tick();
      tick();
      force_on = 1'b0;
      for (int c = 1; c <= IDLE; c++) begin
         tick();
         checks++;
         if (gate_en !== 8'hFF) begin errors++; $display("FAIL fon_release_drain%0d got %h exp ff", c, gate_en); end
      end
      tick();
      checks++;
      if (gate_en !== 8'h00) begin errors++; $display("FAIL fon_release_closed got %h exp 00", gate_en); end
   endtask

   // -------------------------------------------------------------------------
   // Test 6: reset while channel 3 is mid-drain
   // -------------------------------------------------------------------------
   task automatic test_reset_mid_drain();
      en_req = 8'h08;
      d      = 8'h08;
      tick();
      tick();   // open
      tick();   // captures d[3]=1
      en_req = 8'h00;
      tick();   // OPEN with en_q=0
      tick();   // DRAIN, counter 3
      tick();   // DRAIN, counter 2
      checks++;
      if (state_dbg[7:6] !== 2'd2) begin errors++; $display("FAIL mid_drain_state got %0d exp 2", state_dbg[7:6]); end
      checks++;
      if (q[3] !== 1'b1) begin errors++; $display("FAIL mid_drain_q got %b exp 1", q[3]); end
      rst_n = 1'b0;
      tick();
      checks++;
      if (gate_en[3] !== 1'b0) begin errors++; $display("FAIL rst_drain_gate got %b exp 0", gate_en[3]); end
      checks++;
      if (q !== 8'h00) begin errors++; $display("FAIL rst_drain_q got %h exp 00", q); end
      rst_n  = 1'b1;
      en_req = 8'h08;
      tick();
      checks++;
      if (gate_en[3] !== 1'b0) begin errors++; $display("FAIL rst_reopen_edge1 got %b exp 0", gate_en[3]); end
      tick();
      checks++;
      if (gate_en[3] !== 1'b1) begin errors++; $display("FAIL rst_reopen_edge2 got %b exp 1", gate_en[3]); end
      checks++;
      if (wake !== 8'h08) begin errors++; $display("FAIL rst_reopen_wake got %h exp 08", wake); end
   endtask

   // -------------------------------------------------------------------------
   // Sequence and report
   // -------------------------------------------------------------------------
   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      en_req    = '0;
      force_on  = 1'b0;
      force_off = 1'b0;
      d         = '0;
      #1;
      test_reset();
      test_open_latency();
      test_hysteresis();
      test_capture();
      test_overrides();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog_timeout got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
